qsine_voice_arbiter: RTL and testbench
======================================

Name: qsine_voice_arbiter

Overview:
- Shares the single quarter-sine BRAM read port between NUM_VOICES tone generators (arpeggio/chord voices).
- Grants one voice per cycle, round-robin.
- Folds each granted voice's 10-bit phase into a quarter-table address, then mirrors and offsets the returned magnitude into an unsigned full-wave sample.
- Sits between the per-voice phase accumulators and the PWM mixer; the output stream is tagged with the voice index.

Parameters:
- NUM_VOICES, 4: number of requesting voices (2..8).
- VOICE_W, 2: width of the voice index, equal to clog2(NUM_VOICES).
- DATA_W, 11: width of the BRAM word and of the output sample.

Ports:
- CLK100MHZ  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NUM_VOICES  level request per voice.
- phase  input  NUM_VOICES*10  per-voice phase. Voice v uses bits [10v+9:10v]; bits [9:8] are the quadrant, bits [7:0] are the index.
- gnt  output  NUM_VOICES  one-hot grant, registered, 1 cycle wide per grant.
- rom_addr  output  8  quarter-sine BRAM address, registered.
- rom_data  input  DATA_W  BRAM douta, valid 1 cycle after rom_addr is registered.
- sample_valid  output  1  sample strobe.
- sample_voice  output  VOICE_W  voice index of the current sample.
- sample  output  DATA_W  full-wave unsigned sample, midscale 1024.

Behaviour:
- Reset (rst high at an edge), values after that edge:
  - gnt = 0, rom_addr = 0, sample_valid = 0, sample_voice = 0, sample = 1024.
  - Round-robin pointer = NUM_VOICES-1, so voice 0 has first priority.
  - All in-flight pipeline stages are invalidated.
  - Reset mid-operation drops in-flight samples; no sample_valid appears for them.
- Stage 0, edge E0:
  - If req != 0, select the first requesting voice searching upward from pointer+1 with wrap.
  - Register gnt[v]=1, rom_addr, quadrant q = phase_v[9:8], tag v, stage-1 valid.
  - Update pointer = v.
  - If req == 0: gnt = 0, stage-1 valid = 0, rom_addr and pointer hold.
  - The phase is sampled only at the grant edge; later phase changes do not affect that sample.
- Address fold:
  - q = 0 or 2: rom_addr = idx.
  - q = 1 or 3: rom_addr = 255 - idx (bitwise NOT of idx).
- Stage 1, edge E1: BRAM registers douta. Carry q, v and valid one stage further.
- Stage 2, edge E2:
  - q = 0 or 1: sample = 1024 + m.
  - q = 2 or 3: sample = 1023 - m.
  - m = rom_data[9:0]; bit 10 of rom_data is ignored (table peak is 1023). Output range is 0..2047 with no overflow.
  - sample_voice = v, sample_valid = 1.
- Latency: gnt asserted in cycle N gives sample_valid in cycle N+2. Throughput is 1 sample/cycle with no bubbles while any req is high.
- When sample_valid = 0, sample and sample_voice hold their last value.
- Request rules:
  - req is level-sensitive, with no implicit acknowledge.
  - A voice holding req high is re-granted on its next round-robin turn.
  - A voice wanting exactly one sample deasserts req in the cycle after it sees gnt.
  - If req is still high in that cycle, the voice is eligible again only after all other requesters.
- Single requester held high: granted every cycle.
- Quadrant boundaries duplicate table entries 0 and 255; this is intended.
- State held: pointer, 2 pipeline valid bits, 2 tag registers. No FSM beyond the pipeline.

Test Plan:
- BRAM model for all tests: 1-cycle latency, m(a) = 4*a.
1. Reset, then req=0001, phase0=0x040 held 1 cycle:
   - gnt=0001 at N, rom_addr=0x40.
   - At N+2: sample_valid=1, sample_voice=0, sample=1024+256=1280.
   - No further valid.
2. Voice 0 single-shot requests for each quadrant:
   - phase 0x140: rom_addr 0xBF, sample 1024+764=1788.
   - phase 0x240: rom_addr 0x40, sample 1023-256=767.
   - phase 0x3FF: rom_addr 0x00, sample 1023.
   - phase 0x0FF: rom_addr 0xFF, sample 2044.
3. req=1111 held 12 cycles:
   - Grants cycle 0,1,2,3,0,1,2,3,0,1,2,3, one per cycle.
   - sample_voice follows 2 cycles behind with sample_valid continuously 1.
4. Round-robin skip:
   - Grant voice 1, then req=1010: next grant voice 3, then voice 1.
   - Then req=0010 held: voice 1 granted every cycle.
5. Reset during stream:
   - req=1111 running; assert rst for 1 cycle with 2 samples in flight.
   - sample_valid=0 and sample=1024 on the following cycles; no stale sample emerges.
   - After release, the first grant is voice 0.
6. Idle gap:
   - req=0001 for 1 cycle, 0 for 3 cycles, then 0001 again.
   - Exactly 2 sample_valid pulses, separated by 4 cycles.
   - sample holds its value during the gap.

Source files
------------

// File: rtl/qsine_voice_arbiter_if.sv
// Bus between the per-voice phase accumulators, the quarter-sine BRAM and the
// arbiter: requests, grants, BRAM address/data and the tagged sample stream.
interface qsine_voice_arbiter_if #(
  parameter int NUM_VOICES = 4,
  parameter int VOICE_W    = 2,
  parameter int DATA_W     = 11
);
  logic [NUM_VOICES-1:0]    req;
  logic [NUM_VOICES*10-1:0] phase;
  logic [NUM_VOICES-1:0]    gnt;
  logic [7:0]               rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic                     sample_valid;
  logic [VOICE_W-1:0]       sample_voice;
  logic [DATA_W-1:0]        sample;

  modport master (
    output req, phase, rom_data,
    input  gnt, rom_addr, sample_valid, sample_voice, sample
  );

  modport slave (
    input  req, phase, rom_data,
    output gnt, rom_addr, sample_valid, sample_voice, sample
  );
endinterface

// File: rtl/qsine_voice_arbiter.sv
// Round-robin sharing of one quarter-sine BRAM port between NUM_VOICES voices.
// Each grant folds the phase into a table address; two cycles later a full-wave sample emerges.
module qsine_voice_arbiter #(
  parameter int NUM_VOICES = 4,
  parameter int VOICE_W    = 2,
  parameter int DATA_W     = 11
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  qsine_voice_arbiter_if.slave  bus
);
  localparam logic [VOICE_W-1:0] PTR_RST  = VOICE_W'(NUM_VOICES - 1);
  localparam logic [DATA_W-1:0]  MIDSCALE = DATA_W'(1024);
  localparam logic [DATA_W-1:0]  MIDLOW   = DATA_W'(1023);

  logic [VOICE_W-1:0]    ptr_q, ptr_d, sel;
  logic                  found;
  int                    cand;
  logic [9:0]            sel_phase;
  logic [NUM_VOICES-1:0] gnt_q, gnt_d;
  logic [7:0]            addr_q, addr_d;
  logic [1:0]            vld_pipe_q;
  logic [1:0]            quad1_q, quad2_q;
  logic [VOICE_W-1:0]    voice1_q, voice2_q;
  logic [DATA_W-1:0]     sample_q, sample_d;
  logic [VOICE_W-1:0]    svoice_q;
  logic                  svalid_q;
  logic [9:0]            mag;
  logic                  unused_rom_msbs;

  // First requester strictly after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = 0;
    for (int i = 1; i <= NUM_VOICES; i++) begin
      cand = (int'(ptr_q) + i) % NUM_VOICES;
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = VOICE_W'(cand);
      end
    end
  end

  assign sel_phase = bus.phase[10*int'(sel) +: 10];

  always_comb begin
    gnt_d  = '0;
    addr_d = addr_q;
    ptr_d  = ptr_q;
    if (found) begin
      gnt_d[sel] = 1'b1;
      addr_d     = sel_phase[8] ? ~sel_phase[7:0] : sel_phase[7:0];
      ptr_d      = sel;
    end
  end

  // Table peak is 1023, so bit 10 of the BRAM word never carries magnitude.
  assign mag             = bus.rom_data[9:0];
  assign unused_rom_msbs = ^bus.rom_data[DATA_W-1:10];
  assign sample_d        = quad2_q[1] ? (MIDLOW - DATA_W'(mag)) : (MIDSCALE + DATA_W'(mag));

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      ptr_q      <= PTR_RST;
      gnt_q      <= '0;
      addr_q     <= '0;
      vld_pipe_q <= '0;
      quad1_q    <= '0;
      quad2_q    <= '0;
      voice1_q   <= '0;
      voice2_q   <= '0;
      sample_q   <= MIDSCALE;
      svoice_q   <= '0;
      svalid_q   <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      vld_pipe_q <= {vld_pipe_q[0], found};
      if (found) begin
        quad1_q  <= sel_phase[9:8];
        voice1_q <= sel;
      end
      quad2_q  <= quad1_q;
      voice2_q <= voice1_q;
      svalid_q <= vld_pipe_q[1];
      if (vld_pipe_q[1]) begin
        sample_q <= sample_d;
        svoice_q <= voice2_q;
      end
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.rom_addr     = addr_q;
  assign bus.sample_valid = svalid_q;
  assign bus.sample_voice = svoice_q;
  assign bus.sample       = sample_q;
endmodule

// File: tb/tb_qsine_voice_arbiter.sv
// Bench for qsine_voice_arbiter: directed vectors and sequences, plus random
// traffic checked every cycle against a transaction-level reference model.
module tb_qsine_voice_arbiter;
  localparam int NV = 4;
  localparam int VW = 2;
  localparam int DW = 11;
  localparam int PW = NV * 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qsine_voice_arbiter_if #(.NUM_VOICES(NV), .VOICE_W(VW), .DATA_W(DW)) bus();

  qsine_voice_arbiter #(.NUM_VOICES(NV), .VOICE_W(VW), .DATA_W(DW)) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (bus)
  );

  // Quarter-sine BRAM stand-in: one cycle latency, m(a) = 4*a.
  always @(posedge clk) bus.rom_data <= DW'(4 * int'(bus.rom_addr));

  int n_chk  = 0;
  int n_pass = 0;
  bit mchk   = 0;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: who wins each edge, and what sample that grant turns into
  // two cycles later, computed straight from the quadrant/index arithmetic.
  typedef struct { bit v; int voice; int smp; } ev_t;
  ev_t   p1, p2;
  int    m_last = NV - 1;
  int    m_gnt, m_addr, m_voice, m_sample, c, ph, q, idx, a;
  bit    m_valid, won;

  always @(posedge clk) begin
    if (rst) begin
      m_last = NV - 1; m_gnt = 0; m_addr = 0;
      p1.v = 0; p2.v = 0;
      m_valid = 0; m_voice = 0; m_sample = 1024;
    end else begin
      m_valid = p2.v;
      if (p2.v) begin m_voice = p2.voice; m_sample = p2.smp; end
      p2 = p1; p1.v = 0; m_gnt = 0; won = 0;
      for (int k = 1; k <= NV; k++) begin
        c = (m_last + k) % NV;
        if (!won && bus.req[c]) begin
          won = 1;
          ph  = int'((bus.phase >> (10 * c)) & PW'(1023));
          q   = ph / 256;
          idx = ph % 256;
          a   = (q % 2 == 1) ? 255 - idx : idx;
          p1.v = 1; p1.voice = c;
          p1.smp = (q < 2) ? 1024 + 4 * a : 1023 - 4 * a;
          m_gnt  = 1 << c;
          m_addr = a;
        end
      end
      if (won) m_last = p1.voice;
    end
  end

  always @(negedge clk) begin
    if (mchk) begin
      check("model_gnt", int'(bus.gnt), m_gnt);
      check("model_rom_addr", int'(bus.rom_addr), m_addr);
      check("model_valid", int'(bus.sample_valid), int'(m_valid));
      check("model_voice", int'(bus.sample_voice), m_voice);
      check("model_sample", int'(bus.sample), m_sample);
    end
  end

  typedef struct { logic [9:0] ph; int addr; int smp; } vec_t;
  vec_t vecs [5];
  int   pulses [$];
  int   held;

  initial begin
    vecs[0] = '{10'h040, 8'h40, 1280};
    vecs[1] = '{10'h140, 8'hBF, 1788};
    vecs[2] = '{10'h240, 8'h40, 767};
    vecs[3] = '{10'h3FF, 8'h00, 1023};
    vecs[4] = '{10'h0FF, 8'hFF, 2044};

    bus.req = '0; bus.phase = '0;
    tick(2);
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_rom_addr", int'(bus.rom_addr), 0);
    check("rst_valid", int'(bus.sample_valid), 0);
    check("rst_voice", int'(bus.sample_voice), 0);
    check("rst_sample", int'(bus.sample), 1024);
    mchk = 1;
    rst  = 1'b0;
    tick(1);

    // Single-shot requests from voice 0, one per quadrant.
    foreach (vecs[i]) begin
      bus.req = NV'(1); bus.phase = '0; bus.phase[9:0] = vecs[i].ph;
      tick(1);
      check("vec_gnt", int'(bus.gnt), 1);
      check("vec_rom_addr", int'(bus.rom_addr), vecs[i].addr);
      bus.req = '0; bus.phase = PW'(40'h3_FF00_FF00);
      tick(2);
      check("vec_valid", int'(bus.sample_valid), 1);
      check("vec_voice", int'(bus.sample_voice), 0);
      check("vec_sample", int'(bus.sample), vecs[i].smp);
      tick(1);
      check("vec_no_extra", int'(bus.sample_valid), 0);
    end

    // All voices held: strict rotation starting at voice 0 after reset.
    rst = 1'b1; tick(1); rst = 1'b0;
    bus.req = '1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("rr_gnt", int'(bus.gnt), 1 << (i % NV));
      if (i >= 2) begin
        check("rr_valid", int'(bus.sample_valid), 1);
        check("rr_voice", int'(bus.sample_voice), (i - 2) % NV);
      end
    end
    bus.req = '0; tick(3);

    // Skip non-requesters; a voice still requesting goes behind the others.
    bus.req = NV'(4'b0010); tick(1);
    check("skip_gnt1", int'(bus.gnt), 4'b0010);
    bus.req = NV'(4'b1010); tick(1);
    check("skip_gnt3", int'(bus.gnt), 4'b1000);
    tick(1);
    check("skip_gnt1b", int'(bus.gnt), 4'b0010);
    bus.req = NV'(4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("solo_gnt", int'(bus.gnt), 4'b0010);
    end
    bus.req = '0; tick(3);

    // Reset with two samples in flight.
    bus.req = '1; tick(4);
    rst = 1'b1; tick(1);
    check("mid_rst_gnt", int'(bus.gnt), 0);
    check("mid_rst_valid", int'(bus.sample_valid), 0);
    check("mid_rst_sample", int'(bus.sample), 1024);
    rst = 1'b0; tick(1);
    check("post_rst_gnt", int'(bus.gnt), 1);
    check("post_rst_stale0", int'(bus.sample_valid), 0);
    check("post_rst_sample", int'(bus.sample), 1024);
    tick(1);
    check("post_rst_stale1", int'(bus.sample_valid), 0);
    tick(1);
    check("post_rst_first", int'(bus.sample_valid), 1);
    check("post_rst_voice", int'(bus.sample_voice), 0);
    bus.req = '0; tick(3);

    // Idle gap: two isolated grants four cycles apart.
    held = -1;
    for (int t = 0; t < 10; t++) begin
      bus.req = (t == 0 || t == 4) ? NV'(1) : '0;
      bus.phase = '0;
      bus.phase[9:0] = (t == 0) ? 10'h080 : (t == 4) ? 10'h0C0 : 10'h3AB;
      tick(1);
      if (bus.sample_valid) pulses.push_back(t);
      if (t == 4) held = int'(bus.sample);
      if (t == 6) check("gap_sample2", int'(bus.sample), 1792);
    end
    check("gap_pulses", pulses.size(), 2);
    if (pulses.size() == 2) check("gap_spacing", pulses[1] - pulses[0], 4);
    check("gap_hold", held, 1536);

    // Random traffic with occasional resets; the model checks every cycle.
    for (int t = 0; t < 400; t++) begin
      bus.req   = ($urandom_range(0, 3) == 0) ? '0 : NV'($urandom);
      bus.phase = PW'({$urandom, $urandom});
      rst       = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    rst = 1'b0; bus.req = '0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
